// File: rtl/tas_lock_initiator.sv
// rtl/tas_lock_initiator.sv - test-and-set spinlock initiator for a grant-based interconnect master port
module tas_lock_initiator #(
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int BACKOFF_MIN    = 4,
  parameter int BACKOFF_MAX    = 256,
  parameter int MAX_RETRIES    = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      acquire_i,
  input  logic                      release_i,
  input  logic [ADDR_MEM_WIDTH-2:0] lock_addr_i,
  output logic                      locked_o,
  output logic                      busy_o,
  output logic                      fail_o,
  output logic                      released_o,
  output logic [CNT_WIDTH-1:0]      attempts_o,
  output logic                      data_req_o,
  output logic [ADDR_MEM_WIDTH-1:0] data_add_o,
  output logic                      data_wen_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  output logic [BE_WIDTH-1:0]       data_be_o,
  input  logic                      data_gnt_i,
  input  logic                      data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]     data_r_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    TS_REQ,
    TS_WAIT,
    BACKOFF,
    LOCKED,
    REL_REQ,
    REL_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MIN_W     = CNT_WIDTH'(BACKOFF_MIN);
  localparam logic [CNT_WIDTH-1:0] MAX_W     = CNT_WIDTH'(BACKOFF_MAX);
  localparam logic [CNT_WIDTH:0]   MAX_W_EXT = (CNT_WIDTH + 1)'(BACKOFF_MAX);
  localparam logic [CNT_WIDTH-1:0] RETRY_LIM = CNT_WIDTH'(MAX_RETRIES);

  state_t                    state;
  logic [ADDR_MEM_WIDTH-2:0] addr_q;
  logic [CNT_WIDTH-1:0]      window;
  logic [CNT_WIDTH-1:0]      backoff_cnt;

  logic [CNT_WIDTH-1:0]      attempts_inc;
  logic [CNT_WIDTH:0]        window_dbl;
  logic [CNT_WIDTH-1:0]      window_next;
  logic                      abort_hit;

  // Saturating attempt increment, doubled backoff window clamped to the ceiling, abort detection
  always_comb begin
    attempts_inc = (attempts_o == '1) ? attempts_o : attempts_o + CNT_WIDTH'(1);
    window_dbl   = {window, 1'b0};
    window_next  = (window_dbl > MAX_W_EXT) ? MAX_W : window_dbl[CNT_WIDTH-1:0];
    abort_hit    = (MAX_RETRIES != 0) && (attempts_inc == RETRY_LIM);
  end

  // Byte enables are constant: lock words are always accessed whole
  assign data_be_o = '1;

  // Busy covers every in-flight or backing-off state
  assign busy_o = (state != IDLE) && (state != LOCKED);

  // Main FSM; every network-facing output is registered and only changes on state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      window       <= MIN_W;
      backoff_cnt  <= '0;
      data_req_o   <= 1'b0;
      data_add_o   <= '0;
      data_wen_o   <= 1'b1;
      data_wdata_o <= '0;
      locked_o     <= 1'b0;
      fail_o       <= 1'b0;
      released_o   <= 1'b0;
      attempts_o   <= '0;
    end else begin
      fail_o     <= 1'b0;
      released_o <= 1'b0;
      case (state)
        IDLE: begin
          if (acquire_i) begin
            addr_q       <= lock_addr_i;
            attempts_o   <= '0;
            window       <= MIN_W;
            data_req_o   <= 1'b1;
            data_add_o   <= {1'b1, lock_addr_i};
            data_wen_o   <= 1'b1;
            data_wdata_o <= '0;
            state        <= TS_REQ;
          end
        end
        TS_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= TS_WAIT;
          end
        end
        TS_WAIT: begin
          if (data_r_valid_i) begin
            if (data_r_rdata_i == '0) begin
              locked_o <= 1'b1;
              state    <= LOCKED;
            end else begin
              attempts_o <= attempts_inc;
              if (abort_hit) begin
                fail_o <= 1'b1;
                state  <= IDLE;
              end else begin
                backoff_cnt <= window;
                window      <= window_next;
                state       <= BACKOFF;
              end
            end
          end
        end
        BACKOFF: begin
          backoff_cnt <= backoff_cnt - CNT_WIDTH'(1);
          if (backoff_cnt < CNT_WIDTH'(2)) begin
            data_req_o <= 1'b1;
            data_add_o <= {1'b1, addr_q};
            data_wen_o <= 1'b1;
            state      <= TS_REQ;
          end
        end
        LOCKED: begin
          if (release_i) begin
            data_req_o   <= 1'b1;
            data_add_o   <= {1'b0, addr_q};
            data_wen_o   <= 1'b0;
            data_wdata_o <= '0;
            state        <= REL_REQ;
          end
        end
        REL_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            locked_o   <= 1'b0;
            state      <= REL_WAIT;
          end
        end
        REL_WAIT: begin
          if (data_r_valid_i) begin
            released_o <= 1'b1;
            data_wen_o <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tas_lock_initiator.sv
// tb/tb_tas_lock_initiator.sv - directed self-checking bench for tas_lock_initiator
module tb_tas_lock_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acquire;
  logic        release_req;
  logic [10:0] lock_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        locked   [3];
  logic        busy     [3];
  logic        fail     [3];
  logic        released [3];
  logic        req      [3];
  logic        wen      [3];
  logic [15:0] attempts [3];
  logic [11:0] add      [3];
  logic [31:0] wdata    [3];
  logic [3:0]  be       [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults; instance 1: window ceiling 8; instance 2: abort after 2 failures
  for (genvar g = 0; g < 3; g++) begin : g_dut
    tas_lock_initiator #(
      .BACKOFF_MAX (g == 1 ? 8 : 256),
      .MAX_RETRIES (g == 2 ? 2 : 0)
    ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .acquire_i      (acquire),
      .release_i      (release_req),
      .lock_addr_i    (lock_addr),
      .locked_o       (locked[g]),
      .busy_o         (busy[g]),
      .fail_o         (fail[g]),
      .released_o     (released[g]),
      .attempts_o     (attempts[g]),
      .data_req_o     (req[g]),
      .data_add_o     (add[g]),
      .data_wen_o     (wen[g]),
      .data_wdata_o   (wdata[g]),
      .data_be_o      (be[g]),
      .data_gnt_i     (gnt),
      .data_r_valid_i (rvalid),
      .data_r_rdata_i (rdata)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; acquire = 1'b0; release_req = 1'b0; lock_addr = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Pulse acquire for one cycle; returns in the first TS_REQ cycle
  task automatic start_acquire(input logic [10:0] a);
    lock_addr = a;
    acquire = 1'b1;
    tick();
    acquire = 1'b0;
  endtask

  // Grant the pending T&S request, then return response rd; returns in the cycle after r_valid
  task automatic ts_round(input logic [31:0] rd);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = rd;
    tick();
    rvalid = 1'b0;
    rdata = '0;
  endtask

  // Cycles from the r_valid cycle until req rises on instance i; -1 on timeout
  task automatic wait_req(input int i, output int gap);
    gap = 1;
    while (req[i] !== 1'b1 && gap < 100) begin
      tick();
      gap++;
    end
    if (req[i] !== 1'b1) gap = -1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req[0] !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req[0]); end
    n_checks++; if (add[0] !== 12'h000) begin n_fail++; $display("FAIL rst_add: got %h want 000", add[0]); end
    n_checks++; if (wen[0] !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b want 1", wen[0]); end
    n_checks++; if (wdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", wdata[0]); end
    n_checks++; if ({locked[0], busy[0], fail[0], released[0]} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {locked[0], busy[0], fail[0], released[0]}); end
    n_checks++; if (attempts[0] !== 16'd0) begin n_fail++; $display("FAIL rst_attempts: got %0d want 0", attempts[0]); end
    n_checks++; if (be[0] !== 4'hF) begin n_fail++; $display("FAIL rst_be: got %h want f", be[0]); end
  endtask

  task automatic test_uncontended();
    do_reset();
    start_acquire(11'h02A);
    n_checks++; if (req[0] !== 1'b1) begin n_fail++; $display("FAIL unc_req_c1: got %b want 1", req[0]); end
    n_checks++; if (add[0] !== 12'h82A) begin n_fail++; $display("FAIL unc_add: got %h want 82a", add[0]); end
    n_checks++; if (wen[0] !== 1'b1) begin n_fail++; $display("FAIL unc_wen: got %b want 1", wen[0]); end
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL unc_busy: got %b want 1", busy[0]); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    n_checks++; if (req[0] !== 1'b0) begin n_fail++; $display("FAIL unc_req_c2: got %b want 0", req[0]); end
    n_checks++; if (locked[0] !== 1'b0) begin n_fail++; $display("FAIL unc_locked_c2: got %b want 0", locked[0]); end
    rvalid = 1'b1; rdata = 32'h0;
    tick();
    rvalid = 1'b0;
    n_checks++; if (locked[0] !== 1'b1) begin n_fail++; $display("FAIL unc_locked_c3: got %b want 1", locked[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL unc_busy_c3: got %b want 0", busy[0]); end
    n_checks++; if (attempts[0] !== 16'd0) begin n_fail++; $display("FAIL unc_attempts: got %0d want 0", attempts[0]); end
  endtask

  task automatic test_contention();
    int exp_gap [3];
    int gap;
    exp_gap[0] = 5; exp_gap[1] = 9; exp_gap[2] = 17;
    do_reset();
    start_acquire(11'h02A);
    for (int k = 0; k < 3; k++) begin
      ts_round(32'hFFFF_FFFF);
      n_checks++; if (attempts[0] !== 16'(k + 1)) begin n_fail++; $display("FAIL cont_attempts_%0d: got %0d want %0d", k, attempts[0], k + 1); end
      wait_req(0, gap);
      n_checks++; if (gap !== exp_gap[k]) begin n_fail++; $display("FAIL cont_gap_%0d: got %0d want %0d", k, gap, exp_gap[k]); end
    end
    n_checks++; if (add[0] !== 12'h82A) begin n_fail++; $display("FAIL cont_retry_add: got %h want 82a", add[0]); end
    ts_round(32'h0);
    n_checks++; if (locked[0] !== 1'b1) begin n_fail++; $display("FAIL cont_locked: got %b want 1", locked[0]); end
    n_checks++; if (attempts[0] !== 16'd3) begin n_fail++; $display("FAIL cont_final_attempts: got %0d want 3", attempts[0]); end
  endtask

  task automatic test_window_saturation();
    int exp_gap [6];
    int gap;
    exp_gap[0] = 5; exp_gap[1] = 9; exp_gap[2] = 9; exp_gap[3] = 9; exp_gap[4] = 9; exp_gap[5] = 9;
    do_reset();
    start_acquire(11'h101);
    for (int k = 0; k < 6; k++) begin
      ts_round(32'h0000_0001);
      wait_req(1, gap);
      n_checks++; if (gap !== exp_gap[k]) begin n_fail++; $display("FAIL sat_gap_%0d: got %0d want %0d", k, gap, exp_gap[k]); end
    end
    ts_round(32'h0);
    n_checks++; if (locked[1] !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %b want 1", locked[1]); end
    n_checks++; if (attempts[1] !== 16'd6) begin n_fail++; $display("FAIL sat_attempts: got %0d want 6", attempts[1]); end
  endtask

  task automatic test_abort();
    int gap;
    int req_seen;
    do_reset();
    start_acquire(11'h033);
    ts_round(32'hDEAD_BEEF);
    n_checks++; if (fail[2] !== 1'b0) begin n_fail++; $display("FAIL abort_early_fail: got %b want 0", fail[2]); end
    wait_req(2, gap);
    n_checks++; if (gap !== 5) begin n_fail++; $display("FAIL abort_gap: got %0d want 5", gap); end
    ts_round(32'h0000_0080);
    n_checks++; if (fail[2] !== 1'b1) begin n_fail++; $display("FAIL abort_fail_pulse: got %b want 1", fail[2]); end
    n_checks++; if ({locked[2], busy[2]} !== 2'b00) begin n_fail++; $display("FAIL abort_state: got locked/busy %b want 00", {locked[2], busy[2]}); end
    n_checks++; if (attempts[2] !== 16'd2) begin n_fail++; $display("FAIL abort_attempts: got %0d want 2", attempts[2]); end
    tick();
    n_checks++; if (fail[2] !== 1'b0) begin n_fail++; $display("FAIL abort_fail_width: got %b want 0", fail[2]); end
    req_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (req[2] === 1'b1) req_seen++;
      tick();
    end
    n_checks++; if (req_seen !== 0) begin n_fail++; $display("FAIL abort_no_req: got %0d req cycles want 0", req_seen); end
  endtask

  task automatic test_release_stall();
    int bad;
    do_reset();
    start_acquire(11'h02A);
    ts_round(32'h0);
    n_checks++; if (locked[0] !== 1'b1) begin n_fail++; $display("FAIL rel_locked_pre: got %b want 1", locked[0]); end
    acquire = 1'b1;
    tick();
    acquire = 1'b0;
    n_checks++; if ({locked[0], req[0]} !== 2'b10) begin n_fail++; $display("FAIL rel_acq_ignored: got locked/req %b want 10", {locked[0], req[0]}); end
    release_req = 1'b1;
    tick();
    release_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (!(req[0] === 1'b1 && add[0] === 12'h02A && wen[0] === 1'b0 && wdata[0] === 32'h0 && locked[0] === 1'b1)) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rel_stall_stable: got %0d unstable cycles want 0", bad); end
    gnt = 1'b1;
    n_checks++; if ({req[0], locked[0]} !== 2'b11) begin n_fail++; $display("FAIL rel_gnt_cycle: got req/locked %b want 11", {req[0], locked[0]}); end
    tick();
    gnt = 1'b0;
    n_checks++; if ({req[0], locked[0], busy[0], released[0]} !== 4'b0010) begin n_fail++; $display("FAIL rel_wait: got req/locked/busy/released %b want 0010", {req[0], locked[0], busy[0], released[0]}); end
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    n_checks++; if ({released[0], busy[0]} !== 2'b10) begin n_fail++; $display("FAIL rel_released_pulse: got released/busy %b want 10", {released[0], busy[0]}); end
    tick();
    n_checks++; if (released[0] !== 1'b0) begin n_fail++; $display("FAIL rel_released_width: got %b want 0", released[0]); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    start_acquire(11'h015);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++; if ({req[0], wen[0], busy[0], locked[0]} !== 4'b0100) begin n_fail++; $display("FAIL rstw_async: got req/wen/busy/locked %b want 0100", {req[0], wen[0], busy[0], locked[0]}); end
    n_checks++; if (add[0] !== 12'h000) begin n_fail++; $display("FAIL rstw_add: got %h want 000", add[0]); end
    tick();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h0;
    tick();
    rvalid = 1'b0;
    n_checks++; if ({req[0], busy[0], locked[0]} !== 3'b000) begin n_fail++; $display("FAIL rstw_stale_ignored: got req/busy/locked %b want 000", {req[0], busy[0], locked[0]}); end
    start_acquire(11'h02A);
    n_checks++; if ({req[0], add[0]} !== {1'b1, 12'h82A}) begin n_fail++; $display("FAIL rstw_reacq: got req %b add %h want 1 82a", req[0], add[0]); end
    ts_round(32'h0);
    n_checks++; if (locked[0] !== 1'b1) begin n_fail++; $display("FAIL rstw_locked: got %b want 1", locked[0]); end
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_contention();
    test_window_saturation();
    test_abort();
    test_release_stall();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
